// File: rtl/tamagotchi_pkg.sv
// Shared constants for the Tamagotchi core: button front-end FSM encodings and timing defaults.
package tamagotchi_pkg;

   localparam int unsigned DEBOUNCE_CICLOS_DEF = 500000;   // 10 ms at 50 MHz
   localparam int unsigned JANELA_CICLOS_DEF   = 2500000;  // 50 ms at 50 MHz
   localparam int unsigned DEBOUNCE_CICLOS_SIM = 4;
   localparam int unsigned JANELA_CICLOS_SIM   = 8;

   localparam logic [2:0] EST_OCIOSO  = 3'd0;
   localparam logic [2:0] EST_ESPERA1 = 3'd1;
   localparam logic [2:0] EST_ESPERA2 = 3'd2;
   localparam logic [2:0] EST_EMITE   = 3'd3;
   localparam logic [2:0] EST_SOLTURA = 3'd4;

   typedef enum logic [2:0] {
      OCIOSO  = EST_OCIOSO,
      ESPERA1 = EST_ESPERA1,
      ESPERA2 = EST_ESPERA2,
      EMITE   = EST_EMITE,
      SOLTURA = EST_SOLTURA
   } estado_t;

   localparam logic [1:0] MASK_NADA  = 2'b00;
   localparam logic [1:0] MASK_B1    = 2'b01;
   localparam logic [1:0] MASK_B2    = 2'b10;
   localparam logic [1:0] MASK_AMBOS = 2'b11;

endpackage

// File: rtl/debounce_botao.sv
// One push-button: two-flop synchronizer, stable-level debouncer and press-edge detector.
module debounce_botao
   import tamagotchi_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic botao_n,
   output logic est,
   output logic press_c
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CICLOS);

   if (DEBOUNCE_CICLOS < 2) begin : g_debounce_invalido
      $error("debounce_botao: DEBOUNCE_CICLOS must be >= 2");
   end

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          est_q, est_d;
   logic          est_prev_q, est_prev_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Accepted level only flips after DEBOUNCE_CICLOS consecutive disagreeing samples.
   always_comb begin
      sync1_d    = botao_n;
      sync2_d    = sync1_q;
      est_d      = est_q;
      est_prev_d = est_q;
      cnt_d      = '0;
      if ((!sync2_q) != est_q) begin
         if (cnt_q == CW'(DEBOUNCE_CICLOS - 1)) begin
            est_d = !est_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         est_q      <= 1'b0;
         est_prev_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         est_q      <= est_d;
         est_prev_q <= est_prev_d;
         cnt_q      <= cnt_d;
      end
   end

   assign est     = est_q;
   assign press_c = est_q & ~est_prev_q;

endmodule

// File: rtl/tratador_botoes.sv
// Button front end: debounces both buttons and merges near-simultaneous presses
// into a single combined b1/b2 command pulse.
module tratador_botoes
   import tamagotchi_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_DEF,
   parameter int unsigned JANELA_CICLOS   = JANELA_CICLOS_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic botao1_n,
   input  logic botao2_n,
   output logic b1,
   output logic b2
);

   localparam int unsigned TW = $clog2(JANELA_CICLOS);

   if (JANELA_CICLOS < 2) begin : g_janela_invalida
      $error("tratador_botoes: JANELA_CICLOS must be >= 2");
   end

   logic est1, est2;
   logic press1_c, press2_c;

   debounce_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_botao1 (
      .clk     (clk),
      .rst     (rst),
      .botao_n (botao1_n),
      .est     (est1),
      .press_c (press1_c)
   );

   debounce_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_botao2 (
      .clk     (clk),
      .rst     (rst),
      .botao_n (botao2_n),
      .est     (est2),
      .press_c (press2_c)
   );

   estado_t       estado_q, estado_d;
   logic [1:0]    mask_q, mask_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          b1_q, b1_d;
   logic          b2_q, b2_d;

   // Combo FSM; the pulse registers follow the next state so b1/b2 are high exactly in EMITE.
   always_comb begin
      estado_d = estado_q;
      mask_d   = mask_q;
      timer_d  = '0;
      unique case (estado_q)
         OCIOSO: begin
            if (press1_c && press2_c) begin
               estado_d = EMITE;
               mask_d   = MASK_AMBOS;
            end else if (press1_c) begin
               estado_d = ESPERA1;
            end else if (press2_c) begin
               estado_d = ESPERA2;
            end
         end
         ESPERA1: begin
            if (press2_c) begin
               estado_d = EMITE;
               mask_d   = MASK_AMBOS;
            end else if (timer_q == TW'(JANELA_CICLOS - 1)) begin
               estado_d = EMITE;
               mask_d   = MASK_B1;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         ESPERA2: begin
            if (press1_c) begin
               estado_d = EMITE;
               mask_d   = MASK_AMBOS;
            end else if (timer_q == TW'(JANELA_CICLOS - 1)) begin
               estado_d = EMITE;
               mask_d   = MASK_B2;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         EMITE: begin
            estado_d = SOLTURA;
         end
         SOLTURA: begin
            if (!est1 && !est2) begin
               estado_d = OCIOSO;
               mask_d   = MASK_NADA;
            end
         end
         default: begin
            estado_d = OCIOSO;
            mask_d   = MASK_NADA;
         end
      endcase
      b1_d = (estado_d == EMITE) & mask_d[0];
      b2_d = (estado_d == EMITE) & mask_d[1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         estado_q <= OCIOSO;
         mask_q   <= MASK_NADA;
         timer_q  <= '0;
         b1_q     <= 1'b0;
         b2_q     <= 1'b0;
      end else begin
         estado_q <= estado_d;
         mask_q   <= mask_d;
         timer_q  <= timer_d;
         b1_q     <= b1_d;
         b2_q     <= b2_d;
      end
   end

   assign b1 = b1_q;
   assign b2 = b2_q;

endmodule

// File: tb/tb_tratador_botoes.sv
// Bench for tratador_botoes: directed scenarios plus random button activity, checked
// every cycle against an event-level model of debounce, combo window and release lock.
module tb_tratador_botoes;
   import tamagotchi_pkg::*;

   localparam int D = int'(DEBOUNCE_CICLOS_SIM);
   localparam int J = int'(JANELA_CICLOS_SIM);

   localparam int M_IDLE = 0;
   localparam int M_WAIT = 1;
   localparam int M_EMIT = 2;
   localparam int M_LOCK = 3;

   logic clk      = 1'b0;
   logic rst      = 1'b1;
   logic botao1_n = 1'b1;
   logic botao2_n = 1'b1;
   logic b1;
   logic b2;

   tratador_botoes #(
      .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS_SIM),
      .JANELA_CICLOS   (JANELA_CICLOS_SIM)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .botao1_n (botao1_n),
      .botao2_n (botao2_n),
      .b1       (b1),
      .b2       (b2)
   );

   always #5 clk = ~clk;

   // Model state: raw samples delayed two edges, accepted levels, stability runs, combo mode.
   int         cyc = 0;
   logic [1:0] m_h1 = 2'b11;
   logic [1:0] m_h2 = 2'b11;
   logic [1:0] m_est = 2'b00;
   logic [1:0] m_estp = 2'b00;
   int         m_run [2] = '{0, 0};
   int         m_mode = M_IDLE;
   int         m_wait_btn = 0;
   int         m_deadline = 0;
   logic       exp_b1 = 1'b0;
   logic       exp_b2 = 1'b0;
   logic       m_p1, m_p2;
   logic [1:0] m_raw, m_seen;

   always @(posedge clk) begin
      cyc++;
      m_raw = {botao2_n, botao1_n};
      if (rst) begin
         m_h1 = 2'b11; m_h2 = 2'b11;
         m_est = 2'b00; m_estp = 2'b00;
         m_run[0] = 0; m_run[1] = 0;
         m_mode = M_IDLE;
         exp_b1 = 1'b0; exp_b2 = 1'b0;
      end else begin
         m_p1 = m_est[0] & ~m_estp[0];
         m_p2 = m_est[1] & ~m_estp[1];
         exp_b1 = 1'b0; exp_b2 = 1'b0;
         case (m_mode)
            M_IDLE: begin
               if (m_p1 && m_p2) begin
                  m_mode = M_EMIT; exp_b1 = 1'b1; exp_b2 = 1'b1;
               end else if (m_p1 || m_p2) begin
                  m_mode = M_WAIT; m_wait_btn = m_p1 ? 0 : 1; m_deadline = cyc + J;
               end
            end
            M_WAIT: begin
               if ((m_wait_btn == 0) ? m_p2 : m_p1) begin
                  m_mode = M_EMIT; exp_b1 = 1'b1; exp_b2 = 1'b1;
               end else if (cyc == m_deadline) begin
                  m_mode = M_EMIT;
                  if (m_wait_btn == 0) exp_b1 = 1'b1; else exp_b2 = 1'b1;
               end
            end
            M_EMIT: m_mode = M_LOCK;
            default: if (m_est == 2'b00) m_mode = M_IDLE;
         endcase
         m_estp = m_est;
         m_seen = ~m_h2;
         for (int k = 0; k < 2; k++) begin
            if (m_seen[k] != m_est[k]) begin
               m_run[k]++;
               if (m_run[k] == D) begin
                  m_est[k] = ~m_est[k];
                  m_run[k] = 0;
               end
            end else begin
               m_run[k] = 0;
            end
         end
         m_h2 = m_h1;
         m_h1 = m_raw;
      end
   end

   // Per-cycle compare and pulse bookkeeping, away from the active edge.
   int cyc_checks = 0;
   int cyc_fails  = 0;
   int n_b1 = 0, n_b2 = 0, n_combo = 0;
   int last_b1 = -1, last_b2 = -1;

   always @(negedge clk) begin
      cyc_checks++;
      if (b1 !== exp_b1 || b2 !== exp_b2) begin
         cyc_fails++;
         $display("FAIL cycle_compare cyc=%0d got b1=%b b2=%b expected b1=%b b2=%b",
                  cyc, b1, b2, exp_b1, exp_b2);
      end
      if (b1 === 1'b1) begin n_b1++; last_b1 = cyc; end
      if (b2 === 1'b1) begin n_b2++; last_b2 = cyc; end
      if (b1 === 1'b1 && b2 === 1'b1) n_combo++;
   end

   int lit_checks = 0;
   int lit_fails  = 0;

   task automatic chk(input string name, input int got, input int exp_v);
      lit_checks++;
      if (got != exp_v) begin
         lit_fails++;
         $display("FAIL %s got %0d expected %0d", name, got, exp_v);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, s1, s2, sc;

      // Reset
      rst = 1'b1;
      step(3);
      chk("reset_b1", int'(b1), 0);
      chk("reset_b2", int'(b2), 0);
      rst = 1'b0;
      step(50);
      chk("reset_quiet_pulses", n_b1 + n_b2, 0);

      // Solo press on button 1
      s1 = n_b1; s2 = n_b2;
      c = cyc;
      botao1_n = 1'b0;
      step(40);
      chk("solo_b1_count", n_b1 - s1, 1);
      chk("solo_b2_count", n_b2 - s2, 0);
      chk("solo_b1_latency", last_b1 - c, 1 + 2 + D + J);
      botao1_n = 1'b1;
      step(20);
      chk("solo_no_repeat", n_b1 - s1, 1);

      // Bounce shorter than the debounce time, then bounce settling low
      s1 = n_b1; s2 = n_b2;
      for (int i = 0; i < 10; i++) begin
         botao2_n = ~botao2_n;
         step(2);
      end
      step(20);
      chk("bounce_no_pulse", n_b2 - s2, 0);
      for (int i = 0; i < 5; i++) begin
         botao2_n = ~botao2_n;
         step(2);
      end
      step(30);
      botao2_n = 1'b1;
      step(20);
      chk("bounce_settle_b2", n_b2 - s2, 1);
      chk("bounce_settle_b1", n_b1 - s1, 0);

      // Combo inside the window
      s1 = n_b1; s2 = n_b2; sc = n_combo;
      botao1_n = 1'b0;
      step(5);
      botao2_n = 1'b0;
      step(40);
      chk("combo_count", n_combo - sc, 1);
      chk("combo_b1_total", n_b1 - s1, 1);
      chk("combo_b2_total", n_b2 - s2, 1);
      botao1_n = 1'b1; botao2_n = 1'b1;
      step(20);

      // Window expiry: button 2 solo, late button 1 swallowed until full release
      s1 = n_b1; s2 = n_b2; sc = n_combo;
      botao2_n = 1'b0;
      step(12);
      botao1_n = 1'b0;
      step(40);
      chk("expiry_b2", n_b2 - s2, 1);
      chk("expiry_b1", n_b1 - s1, 0);
      chk("expiry_combo", n_combo - sc, 0);
      botao1_n = 1'b1; botao2_n = 1'b1;
      step(20);
      chk("expiry_after_release", n_b1 - s1, 0);

      // Reset in the middle of the ESPERA1 window, button still held
      s1 = n_b1; s2 = n_b2;
      botao1_n = 1'b0;
      step(9);
      rst = 1'b1;
      step(3);
      chk("midwait_reset_none", (n_b1 - s1) + (n_b2 - s2), 0);
      c = cyc;
      rst = 1'b0;
      step(40);
      chk("midwait_after_b1", n_b1 - s1, 1);
      chk("midwait_after_latency", last_b1 - c, 1 + 2 + D + J);
      botao1_n = 1'b1;
      step(20);

      // Random activity against the model
      for (int i = 0; i < 300; i++) begin
         botao1_n = 1'($urandom_range(0, 1));
         botao2_n = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 49) == 0) begin
            rst = 1'b1;
            step(int'($urandom_range(1, 3)));
            rst = 1'b0;
         end
         step(int'($urandom_range(1, 14)));
      end
      botao1_n = 1'b1; botao2_n = 1'b1;
      step(30);

      $display("%0d/%0d checks passed",
               (cyc_checks - cyc_fails) + (lit_checks - lit_fails),
               cyc_checks + lit_checks);
      $finish;
   end

endmodule
